// File: rtl/bus_arb_pkg.sv
// Shared definitions for the data-memory bus arbiter: FSM states, requester ids,
// and the default WAIT timeout.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick with a last-grant pointer; on a contest the requester
// that was not granted last wins.
module rr_arbiter2
    import bus_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic update,
    output logic grant_valid,
    output logic grant_id
);

    logic last_grant;

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else if (req1) begin
            grant_id = M_DMA;
        end else begin
            grant_id = M_CPU;
        end
    end

    // Pointer starts at M1 so that M0 wins the first contest out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= M_DMA;
        end else if (update && grant_valid) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single data-memory port between the CPU (M0) and the DMA engine (M1),
// one transaction at a time, with a done/err/rdata pulse back to the owner.
module mem_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic [AW-1:0]   m0_addr,
    input  logic            m0_we,
    input  logic [DW/8-1:0] m0_be,
    input  logic [DW-1:0]   m0_wdata,
    output logic            m0_done,
    output logic            m0_err,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic [AW-1:0]   m1_addr,
    input  logic            m1_we,
    input  logic [DW/8-1:0] m1_be,
    input  logic [DW-1:0]   m1_wdata,
    output logic            m1_done,
    output logic            m1_err,
    output logic [DW-1:0]   m1_rdata,
    output logic            mem_req,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy,
    output logic            owner,
    output logic [1:0]      dbg_state
);

    // Handshake: a requester raises mX_req with its fields and holds them until
    // mX_done; fields are captured at grant, so dropping req mid-transaction has
    // no effect and the transaction still completes with a done pulse.

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] T_MAX  = '1;

    state_t        state;
    logic [TW-1:0] timer;
    logic          grant_valid;
    logic          grant_id;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .reset       (reset),
        .req0        (m0_req),
        .req1        (m1_req),
        .update      (state == ST_IDLE),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            timer     <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            owner     <= M_CPU;
            m0_done   <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_done   <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            m0_done  <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_done  <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant_id;
                        mem_addr  <= (grant_id == M_DMA) ? m1_addr  : m0_addr;
                        mem_we    <= (grant_id == M_DMA) ? m1_we    : m0_we;
                        mem_be    <= (grant_id == M_DMA) ? m1_be    : m0_be;
                        mem_wdata <= (grant_id == M_DMA) ? m1_wdata : m0_wdata;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        timer     <= '0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // An ack arriving on the timeout cycle still completes normally.
                    if (mem_ack || (TIMEOUT > 0 && timer == T_LAST)) begin
                        mem_req <= 1'b0;
                        state   <= ST_RESP;
                        if (owner == M_DMA) begin
                            m1_done  <= 1'b1;
                            m1_err   <= ~mem_ack;
                            m1_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_err   <= ~mem_ack;
                            m0_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                        end
                    end else if (timer != T_MAX) begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-written
// reset/contest/spurious-ack sequences, and a randomized transaction-level check.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_be = '0, m1_be = '0;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_be;
    logic        busy, owner;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner), .dbg_state(dbg_state)
    );

    typedef struct {
        logic        id;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] ack_data;
        int          exp_cycles;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    logic [69:0] exp_q[$];
    logic [32:0] resp_q[$];
    logic [68:0] q0[$];
    logic [68:0] q1[$];

    task automatic chk(input string nm, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic drive_m(input logic id, input logic req, input logic we,
                           input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        if (id) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_be = be; m1_wdata = wd;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_be = be; m0_wdata = wd;
        end
    endtask

    task automatic do_reset();
        drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_m(1'b1, 1'b0, 1'b0, '0, '0, '0);
        mem_ack = 1'b0;
        mem_rdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int wcyc;
        bit got, stable_ok, other_done;
        logic d, e;
        logic [31:0] rd;
        drive_m(v.id, 1'b1, v.we, v.addr, v.be, v.wdata);
        mem_ack = 1'b0;
        wcyc = 0; got = 0; stable_ok = 1; other_done = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (mem_req) begin
                if (wcyc == 0) chk($sformatf("vec%0d_owner", idx), 70'(owner), 70'(v.id));
                if ({mem_we, mem_be, mem_addr, mem_wdata} !== {v.we, v.be, v.addr, v.wdata})
                    stable_ok = 0;
                mem_ack = (wcyc == v.lat);
                mem_rdata = (wcyc == v.lat) ? v.ack_data : 32'($urandom);
                wcyc++;
            end else begin
                mem_ack = 1'b0;
            end
            d  = v.id ? m1_done  : m0_done;
            e  = v.id ? m1_err   : m0_err;
            rd = v.id ? m1_rdata : m0_rdata;
            if (v.id ? (m0_done || m0_rdata != 0) : (m1_done || m1_rdata != 0)) other_done = 1;
            if (d) begin
                got = 1;
                chk($sformatf("vec%0d_err", idx), 70'(e), 70'(v.exp_err));
                chk($sformatf("vec%0d_rdata", idx), 70'(rd), 70'(v.exp_rdata));
                chk($sformatf("vec%0d_busy_resp", idx), 70'(busy), 70'(1));
                drive_m(v.id, 1'b0, 1'b0, '0, '0, '0);
            end
        end
        chk($sformatf("vec%0d_done_seen", idx), 70'(got), 70'(1));
        chk($sformatf("vec%0d_req_cycles", idx), 70'(wcyc), 70'(v.exp_cycles));
        chk($sformatf("vec%0d_fields_stable", idx), 70'(stable_ok), 70'(1));
        @(negedge clk);
        if (v.id ? (m0_done || m0_rdata != 0) : (m1_done || m1_rdata != 0)) other_done = 1;
        chk($sformatf("vec%0d_other_quiet", idx), 70'(other_done), 70'(0));
        chk($sformatf("vec%0d_pulse_end", idx), 70'({m0_done, m1_done, busy}), 70'(0));
    endtask

    initial begin
        int k, ndone, n0, n1, i0, i1, lat, cnt;
        bit prev_req, in_txn, stab, bad_spur, pick, last;
        logic exp_own[4];
        logic [69:0] cur, e70;
        logic [68:0] t;
        logic [32:0] r;
        logic [31:0] rdv;

        vecs[0] = '{1'b0, 1'b0, 32'h100, 4'hF, 32'h0,        2,  32'hDEADBEEF, 3,  1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h200, 4'b0011, 32'h12345678, 1, 32'hFFFFFFFF, 2, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h300, 4'hF, 32'h0,        99, 32'hAAAA5555, 15, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h304, 4'hF, 32'h0,        14, 32'hCAFEF00D, 15, 1'b0, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 1'b0, 32'h400, 4'hF, 32'h0,        0,  32'h0BADC0DE, 1,  1'b0, 32'h0BADC0DE};
        vecs[5] = '{1'b1, 1'b0, 32'h404, 4'hF, 32'h0,        99, 32'h11111111, 15, 1'b1, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 32'h500, 4'hF, 32'h55AA55AA, 0,  32'h77777777, 1,  1'b0, 32'h0};
        exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 70'(mem_req), 70'(0));
        chk("rst_busy", 70'(busy), 70'(0));
        chk("rst_owner", 70'(owner), 70'(0));
        chk("rst_done_err", 70'({m0_done, m0_err, m1_done, m1_err}), 70'(0));
        chk("rst_rdata", 70'({m0_rdata, m1_rdata}), 70'(0));
        chk("rst_mem_fields", 70'({mem_we, mem_be, mem_addr, mem_wdata}), 70'(0));
        reset = 1'b0;

        // Contest straight after reset, both held: grants alternate starting at M0
        drive_m(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, '0);
        drive_m(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, '0);
        k = 0; ndone = 0; prev_req = 0;
        for (int c = 0; c < 60 && ndone < 4; c++) begin
            @(negedge clk);
            if (mem_req && !prev_req && k < 4) begin
                chk($sformatf("contest_grant%0d", k), 70'(owner), 70'(exp_own[k]));
                k++;
            end
            prev_req = mem_req;
            mem_ack = mem_req;
            if (m0_done || m1_done) ndone++;
            if (ndone == 4) begin
                drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
                drive_m(1'b1, 1'b0, 1'b0, '0, '0, '0);
            end
        end
        chk("contest_grants", 70'(k), 70'(4));
        chk("contest_dones", 70'(ndone), 70'(4));
        do_reset();

        // Directed vector table
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset in the middle of WAIT aborts silently and restores the M0 priority
        do_reset();
        drive_m(1'b0, 1'b1, 1'b0, 32'h600, 4'hF, '0);
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_in_wait", 70'({mem_req, owner}), 70'({1'b1, 1'b0}));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_mem_req", 70'(mem_req), 70'(0));
        chk("midrst_busy", 70'(busy), 70'(0));
        chk("midrst_no_done", 70'({m0_done, m1_done}), 70'(0));
        reset = 1'b0;
        drive_m(1'b1, 1'b1, 1'b0, 32'h700, 4'hF, '0);
        @(negedge clk);
        chk("midrst_next_owner", 70'({mem_req, owner}), 70'({1'b1, 1'b0}));
        do_reset();

        // Spurious acks while idle
        bad_spur = 0;
        mem_ack = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mem_req || busy || m0_done || m1_done) bad_spur = 1;
        end
        mem_ack = 1'b0;
        chk("spurious_idle", 70'(bad_spur), 70'(0));

        // Randomized transactions with a transaction-level model of the arbitration order
        do_reset();
        n0 = $urandom_range(4, 8);
        n1 = $urandom_range(4, 8);
        for (int i = 0; i < n0 + n1; i++) begin
            t = {1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                 32'($urandom) & 32'hFFFF_FFFC, 32'($urandom)};
            if (i < n0) q0.push_back(t); else q1.push_back(t);
        end
        i0 = 0; i1 = 0; last = 1'b1;
        while (i0 < n0 || i1 < n1) begin
            if (i0 < n0 && i1 < n1) pick = ~last;
            else pick = (i0 < n0) ? 1'b0 : 1'b1;
            exp_q.push_back(pick ? {1'b1, q1[i1]} : {1'b0, q0[i0]});
            if (pick) i1++; else i0++;
            last = pick;
        end
        in_txn = 0; stab = 1; lat = 0; cnt = 0; cur = '0;
        for (int c = 0; c < 1000 && (q0.size() > 0 || q1.size() > 0); c++) begin
            if (q0.size() > 0) drive_m(1'b0, 1'b1, q0[0][68], q0[0][31:0] == 0 ? q0[0][63:32] : q0[0][63:32], q0[0][67:64], q0[0][31:0]);
            else drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
            if (q1.size() > 0) drive_m(1'b1, 1'b1, q1[0][68], q1[0][63:32], q1[0][67:64], q1[0][31:0]);
            else drive_m(1'b1, 1'b0, 1'b0, '0, '0, '0);
            @(negedge clk);
            if (m0_done) begin
                if (resp_q.size() == 0) chk("rand_unexpected_done0", 70'(1), 70'(0));
                else begin
                    r = resp_q.pop_front();
                    chk("rand_resp0", 70'({1'b0, m0_err, m0_rdata}), 70'({r[32], 1'b0, r[31:0]}));
                end
                if (q0.size() > 0) void'(q0.pop_front());
            end
            if (m1_done) begin
                if (resp_q.size() == 0) chk("rand_unexpected_done1", 70'(1), 70'(0));
                else begin
                    r = resp_q.pop_front();
                    chk("rand_resp1", 70'({1'b1, m1_err, m1_rdata}), 70'({r[32], 1'b0, r[31:0]}));
                end
                if (q1.size() > 0) void'(q1.pop_front());
            end
            if (mem_req) begin
                if (!in_txn) begin
                    if (exp_q.size() == 0) begin
                        chk("rand_unexpected_grant", 70'(1), 70'(0));
                        cur = {owner, mem_we, mem_be, mem_addr, mem_wdata};
                    end else begin
                        cur = exp_q.pop_front();
                        chk("rand_grant", {owner, mem_we, mem_be, mem_addr, mem_wdata}, cur);
                    end
                    lat = $urandom_range(0, 4);
                    cnt = 0;
                    in_txn = 1;
                end else if ({mem_we, mem_be, mem_addr, mem_wdata} !== cur[68:0]) begin
                    stab = 0;
                end
                rdv = 32'($urandom);
                mem_rdata = rdv;
                if (cnt == lat) begin
                    mem_ack = 1'b1;
                    resp_q.push_back({cur[69], cur[68] ? 32'h0 : rdv});
                    in_txn = 0;
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
                mem_rdata = 32'($urandom);
            end
        end
        mem_ack = 1'b0;
        drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_m(1'b1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        e70 = 70'({exp_q.size(), resp_q.size(), q0.size(), q1.size()});
        chk("rand_drained", e70, 70'(0));
        chk("rand_fields_stable", 70'(stab), 70'(1));
        chk("rand_idle_end", 70'({mem_req, busy}), 70'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
